// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - state encoding, opcodes and datapath select codes for the multicycle MIPS control FSM
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the shared multicycle MIPS datapath
// with memory-ready stalls, illegal-opcode flag and retired-instruction counter.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int OPW   = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   Op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              retire;
  logic              op_is_lw, op_is_sw, op_is_r, op_is_beq, op_is_j, op_known;

  always_comb begin
    op_is_lw  = (Op == OPW'(OP_LW));
    op_is_sw  = (Op == OPW'(OP_SW));
    op_is_r   = (Op == OPW'(OP_RTYPE));
    op_is_beq = (Op == OPW'(OP_BEQ));
    op_is_j   = (Op == OPW'(OP_J));
    op_known  = op_is_lw | op_is_sw | op_is_r | op_is_beq | op_is_j;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Retire marks the final transition of a legal instruction back to FETCH.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (op_is_lw || op_is_sw) state_d = S_MEMADDR;
        else if (op_is_r)         state_d = S_EXEC;
        else if (op_is_beq)       state_d = S_BRANCH;
        else if (op_is_j)         state_d = S_JUMP;
        else                      state_d = S_FETCH;
      end
      S_MEMADDR: state_d = op_is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC:    state_d = S_RWB;
      S_RWB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:   state_d = S_FETCH;
    endcase
    cnt_d = cnt_q + CNT_W'(retire);
  end

  assign instr_count = cnt_q;

  // Outputs are held at zero for the whole time rst is asserted, not just after the edge.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = ALUSRCB_B;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    illegal_op  = 1'b0;
    state_o     = 4'd0;
    if (!rst) begin
      state_o = state_q;
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = ALUSRCB_FOUR;
          PCWrite = mem_ready;
          IRWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB    = ALUSRCB_BRANCH;
          illegal_op = ~op_known;
        end
        S_MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = ALUSRCB_IMM;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        S_RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM that sequences the shared multicycle MIPS datapath: one memory, one ALU, PC/IR/A/B/ALUOut registers.
- Every instruction runs fetch, decode, then 1–3 opcode-specific steps.
- Drives all mux selects, register write enables and memory strobes.
- Stalls on a memory ready handshake.
- Counts retired instructions and flags unknown opcodes.
- Supports R-format, lw, sw, beq, j.

Parameters:
- OPW, 6, opcode width.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Op  in  OPW  opcode field from IR; sampled only in DECODE and MEMADDR.
- mem_ready  in  1  memory completes current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU Zero (gated externally).
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write data select: 1=MDR.
- RegDst  out  1  destination register select: 1=rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0=PC, 1=A.
- ALUSrcB  out  2  ALU B select: 00=B, 01=4, 10=signext, 11=signext<<2.
- ALUOp  out  2  00=add, 01=sub, 10=funct.
- PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target.
- illegal_op  out  1  one-cycle pulse on unknown opcode.
- state_o  out  4  current state encoding (debug).
- instr_count  out  CNT_W  retired instruction count.

Behaviour:

Reset:
- rst high → state=FETCH, instr_count=0.
- While rst is high, all outputs are forced 0 combinationally, state_o=0.
- Reset mid-instruction abandons it; no partial retire is counted.

Outputs:
- Pure function of state plus mem_ready.
- Every output not listed for a state is 0.

State encoding and outputs:
- FETCH(0):
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=IRWrite=mem_ready.
  - Next: mem_ready → DECODE, else stay.
- DECODE(1):
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next by Op:
    - 100011 or 101011 → MEMADDR.
    - 000000 → EXEC.
    - 000100 → BRANCH.
    - 000010 → JUMP.
    - anything else → FETCH with illegal_op=1 this cycle.
- MEMADDR(2):
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next: Op=100011 → MEMRD, else MEMWR.
- MEMRD(3):
  - Outputs: MemRead=1, IorD=1.
  - Next: mem_ready → MEMWB, else stay.
- MEMWB(4):
  - Outputs: RegWrite=1, MemtoReg=1, RegDst=0.
  - Next: FETCH; retire.
- MEMWR(5):
  - Outputs: MemWrite=1, IorD=1.
  - Next: mem_ready → FETCH and retire, else stay.
- EXEC(6):
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next: RWB.
- RWB(7):
  - Outputs: RegWrite=1, RegDst=1, MemtoReg=0.
  - Next: FETCH; retire.
- BRANCH(8):
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - Next: FETCH; retire.
- JUMP(9):
  - Outputs: PCWrite=1, PCSource=10.
  - Next: FETCH; retire.

Undefined encodings:
- 10–15 → FETCH next cycle, outputs 0.

Latency with mem_ready held at 1:
- lw 5 cycles.
- sw 4 cycles.
- R-format 4 cycles.
- beq 3 cycles.
- j 3 cycles.
- Each cycle with mem_ready low adds 1 cycle in FETCH, MEMRD or MEMWR.

Strobe rules:
- MemRead and MemWrite are held stable across a stall.
- No output toggles while stalled.

Retire counter:
- instr_count += 1 on each retiring transition, registered.
- Wraps modulo 2^CNT_W silently.
- Illegal opcode does not retire.

Decomposition:
- Package mips_pkg holds:
  - state_t enum with the fixed encodings above.
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J.
  - ALUOp constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT.
  - ALUSrcB and PCSource localparams.
- Single module: state register, next-state always_comb, output always_comb, counter. No sub-module.

Test Plan:
- lw (Op=100011), mem_ready=1:
  - state_o sequence 0,1,2,3,4,0.
  - MemRead high in cycles 1 and 4.
  - RegWrite=MemtoReg=1 in cycle 5.
  - instr_count 0→1.
- R-format (000000):
  - States 0,1,6,7.
  - ALUOp=10 in EXEC.
  - RegDst=RegWrite=1 in RWB.
  - 4 cycles, instr_count+1.
- sw (101011), mem_ready low 2 cycles in MEMWR:
  - MemWrite=1, IorD=1 held 3 cycles.
  - No RegWrite at any point.
  - Returns to FETCH after mem_ready=1.
- Fetch stall, mem_ready=0 for 3 cycles:
  - State holds 0; MemRead=1 throughout.
  - PCWrite=IRWrite=0 until the ready cycle, then both 1 for exactly 1 cycle.
- beq then j:
  - BRANCH: PCWriteCond=1, PCSource=01, ALUOp=01.
  - JUMP: PCWrite=1, PCSource=10.
  - 3 cycles each, count +2.
- Illegal Op=111111:
  - illegal_op pulses 1 cycle in DECODE, then FETCH, count unchanged.
- Async rst asserted mid-MEMRD:
  - All outputs 0 immediately, state_o=0, count=0.
  - After release, FETCH behaviour resumes.
- CNT_W=4, 16 R-format instructions:
  - instr_count wraps 15→0.
